// File: rtl/beep_sequencer.sv
// beep_sequencer: arbitrates buzzer events and plays one beep pattern at a time.
// Event ids: 0 = interval change (1 kHz, 1 beep), 1 = skip (500 Hz, 2 beeps),
// 2 = finish (2 kHz, 3 long beeps). Fixed priority 2 > 1 > 0; finish preempts.
module beep_sequencer #(
    parameter int ON_TICKS   = 20,
    parameter int LONG_TICKS = 50,
    parameter int OFF_TICKS  = 10
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] req,
    input  logic       beep500,
    input  logic       beep1k,
    input  logic       beep2k,
    output logic       BuFreq,
    output logic       busy,
    output logic [2:0] ack,
    output logic [1:0] active_id
);

    localparam int MAX_A = (ON_TICKS > LONG_TICKS) ? ON_TICKS : LONG_TICKS;
    localparam int MAX_T = (MAX_A > OFF_TICKS) ? MAX_A : OFF_TICKS;
    localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [TW-1:0] ON_LAST   = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST  = TW'(OFF_TICKS - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state, state_n;
    logic [2:0]    pending, pending_n;
    logic [2:0]    ack_n;
    logic [1:0]    id_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [1:0]    bcnt, bcnt_n;

    logic          playing2;
    logic [2:0]    req_eff;
    logic [2:0]    cand;
    logic [1:0]    grant_id;
    logic [TW-1:0] phase_last;
    logic          phase_end;
    logic          do_grant;

    // State register; async reset silences the buzzer immediately.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 3'b000;
            tcnt      <= '0;
            bcnt      <= 2'd0;
            ack       <= 3'b000;
            active_id <= 2'd3;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            tcnt      <= tcnt_n;
            bcnt      <= bcnt_n;
            ack       <= ack_n;
            active_id <= id_n;
        end
    end

    // Next-state: arbitration, phase timing, preemption and pending bookkeeping.
    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt;
        bcnt_n    = bcnt;
        id_n      = active_id;
        ack_n     = 3'b000;
        do_grant  = 1'b0;

        // A finish request during a finish pattern is dropped entirely.
        playing2  = (state != IDLE) && (active_id == 2'd2);
        req_eff   = req & {~playing2, 2'b11};
        cand      = pending | req_eff;
        pending_n = pending | req_eff;

        if (cand[2])      grant_id = 2'd2;
        else if (cand[1]) grant_id = 2'd1;
        else              grant_id = 2'd0;

        if (state == ON) phase_last = (active_id == 2'd2) ? LONG_LAST : ON_LAST;
        else             phase_last = OFF_LAST;
        phase_end = tick && (tcnt == phase_last);

        case (state)
            IDLE: begin
                if (|cand) do_grant = 1'b1;
            end
            ON: begin
                if (req_eff[2] && active_id != 2'd2) begin
                    do_grant = 1'b1;
                end else if (phase_end) begin
                    state_n = OFF;
                    tcnt_n  = '0;
                end else if (tick) begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            OFF: begin
                if (req_eff[2] && active_id != 2'd2) begin
                    do_grant = 1'b1;
                end else if (phase_end) begin
                    // Beep count per id is id+1: this was the last beep when bcnt == id.
                    if (bcnt == active_id) begin
                        if (|cand) begin
                            do_grant = 1'b1;
                        end else begin
                            state_n = IDLE;
                            id_n    = 2'd3;
                            tcnt_n  = '0;
                            bcnt_n  = 2'd0;
                        end
                    end else begin
                        state_n = ON;
                        tcnt_n  = '0;
                        bcnt_n  = bcnt + 2'd1;
                    end
                end else if (tick) begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                id_n    = 2'd3;
            end
        endcase

        if (do_grant) begin
            state_n             = ON;
            id_n                = grant_id;
            tcnt_n              = '0;
            bcnt_n              = 2'd0;
            ack_n[grant_id]     = 1'b1;
            pending_n[grant_id] = 1'b0;
            if (grant_id == 2'd2) pending_n = 3'b000;
        end
    end

    // Buzzer output: tone of the playing id while ON, silent otherwise.
    always_comb begin
        BuFreq = 1'b0;
        if (state == ON) begin
            case (active_id)
                2'd0:    BuFreq = beep1k;
                2'd1:    BuFreq = beep500;
                2'd2:    BuFreq = beep2k;
                default: BuFreq = 1'b0;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_beep_sequencer.sv
// tb_beep_sequencer: directed and random requests against a pattern-level model.
// The model tracks each play as "ticks since grant" and derives tone on/off and
// end of pattern arithmetically; a monitor compares every cycle via a queue.
module tb_beep_sequencer;

    localparam int ON_T   = 20;
    localparam int LONG_T = 50;
    localparam int OFF_T  = 10;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [2:0] req = 3'b000;
    logic       beep500 = 1'b0, beep1k = 1'b0, beep2k = 1'b0;
    logic       BuFreq, busy;
    logic [2:0] ack;
    logic [1:0] active_id;

    int checks = 0;
    int errors = 0;
    int tick_mode = 0;   // 0: tick every 4 cycles, 1: random ticks
    int cyc = 0;

    typedef struct packed {
        logic [2:0] ack;
        logic       busy;
        logic [1:0] id;
        logic       tone;
    } exp_t;

    exp_t exp_q[$];

    beep_sequencer #(.ON_TICKS(ON_T), .LONG_TICKS(LONG_T), .OFF_TICKS(OFF_T)) dut (
        .Clk(Clk), .reset(reset), .tick(tick), .req(req),
        .beep500(beep500), .beep1k(beep1k), .beep2k(beep2k),
        .BuFreq(BuFreq), .busy(busy), .ack(ack), .active_id(active_id)
    );

    initial forever #5 Clk = ~Clk;

    // Free-running tone generators, changing just after the rising edge.
    initial begin
        int tc = 0;
        forever begin
            @(posedge Clk);
            #1;
            tc++;
            beep2k  = tc[1];
            beep1k  = tc[2];
            beep500 = tc[3];
        end
    end

    // Tick strobe, driven on the falling edge.
    initial forever begin
        @(negedge Clk);
        cyc++;
        if (tick_mode == 0) tick = (cyc % 4 == 0);
        else                tick = ($urandom_range(0, 2) == 0);
    end

    function automatic int beep_len(input logic [1:0] id);
        return (id == 2'd2) ? LONG_T : ON_T;
    endfunction

    function automatic int period(input logic [1:0] id);
        return beep_len(id) + OFF_T;
    endfunction

    function automatic int total(input logic [1:0] id);
        return (int'(id) + 1) * period(id);
    endfunction

    // Reference model: one play = id plus ticks elapsed since its grant.
    initial begin
        bit         m_play = 0;
        logic [1:0] m_id = 2'd3;
        int         m_tc = 0;
        logic [2:0] m_pend = 3'b000;
        forever begin
            exp_t       e;
            logic [2:0] r, cand;
            logic [1:0] g;
            bit         grant;
            @(posedge Clk);
            e = '0;
            grant = 0;
            if (reset) begin
                m_play = 0; m_id = 2'd3; m_tc = 0; m_pend = 3'b000;
            end else begin
                r = req;
                if (m_play && m_id == 2'd2) r[2] = 1'b0;
                cand   = m_pend | r;
                m_pend = m_pend | r;
                if (m_play && m_id != 2'd2 && r[2]) begin
                    grant = 1;
                end else if (m_play) begin
                    if (tick) m_tc++;
                    if (m_tc == total(m_id)) begin
                        m_play = 0;
                        grant  = (cand != 3'b000);
                    end
                end else if (cand != 3'b000) begin
                    grant = 1;
                end
                if (grant) begin
                    g = cand[2] ? 2'd2 : (cand[1] ? 2'd1 : 2'd0);
                    m_play = 1; m_id = g; m_tc = 0;
                    e.ack[g] = 1'b1;
                    if (g == 2'd2) m_pend = 3'b000;
                    else           m_pend[g] = 1'b0;
                end
            end
            e.busy = m_play;
            e.id   = m_play ? m_id : 2'd3;
            e.tone = m_play && ((m_tc % period(m_id)) < beep_len(m_id));
            exp_q.push_back(e);
        end
    end

    // Monitor: pop one expectation per cycle and compare on the falling edge.
    initial forever begin
        exp_t e;
        logic exp_bu;
        @(negedge Clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at cycle %0d", cyc);
        end else begin
            e = exp_q.pop_front();
            exp_bu = e.tone ? ((e.id == 2'd0) ? beep1k : (e.id == 2'd1) ? beep500 : beep2k) : 1'b0;
            if (ack !== e.ack || busy !== e.busy || active_id !== e.id || BuFreq !== exp_bu) begin
                errors++;
                if (errors <= 30)
                    $display("FAIL cycle_check cyc=%0d got ack=%b busy=%b id=%0d bu=%b want ack=%b busy=%b id=%0d bu=%b",
                             cyc, ack, busy, active_id, BuFreq, e.ack, e.busy, e.id, exp_bu);
            end
        end
    end

    task automatic pulse(input logic [2:0] r);
        @(negedge Clk);
        req = r;
        @(negedge Clk);
        req = 3'b000;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Assert reset between edges and check the outputs drop at once.
    task automatic async_reset_check(input string name);
        @(negedge Clk);
        req = 3'b000;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (BuFreq !== 1'b0 || busy !== 1'b0 || active_id !== 2'd3 || ack !== 3'b000) begin
            errors++;
            $display("FAIL %s got bu=%b busy=%b id=%0d ack=%b want bu=0 busy=0 id=3 ack=000",
                     name, BuFreq, busy, active_id, ack);
        end
        wait_cyc(3);
        reset = 1'b0;
    endtask

    initial begin
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);

        // Single interval beep, then skip pattern.
        pulse(3'b001);
        wait_cyc(140);
        pulse(3'b010);
        wait_cyc(260);

        // Priority and queueing: id 1 first, id 0 straight after.
        pulse(3'b011);
        wait_cyc(400);

        // Preemption of id 0 by finish around tick 5 of ON.
        pulse(3'b001);
        wait_cyc(20);
        pulse(3'b100);
        wait_cyc(200);
        // Finish during finish is ignored.
        pulse(3'b100);
        wait_cyc(560);

        // Three id 0 pulses during id 1 play merge into one replay.
        pulse(3'b010);
        wait_cyc(10);
        pulse(3'b001);
        wait_cyc(30);
        pulse(3'b001);
        wait_cyc(50);
        pulse(3'b001);
        wait_cyc(350);

        // Async reset in the middle of an ON phase.
        pulse(3'b001);
        wait_cyc(20);
        async_reset_check("async_reset_mid_on");
        wait_cyc(200);

        // Random phase with random tick spacing.
        tick_mode = 1;
        for (int i = 0; i < 15000; i++) begin
            @(negedge Clk);
            if ($urandom_range(0, 99) < 3) req = 3'($urandom_range(1, 7));
            else                           req = 3'b000;
            if (i == 7000) async_reset_check("async_reset_random");
        end
        @(negedge Clk);
        req = 3'b000;
        wait_cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
